// File: rtl/stage_ctrl_pkg.sv
// Shared definitions for the stage-controller protocol: stage codes,
// command/acknowledge bit offsets, broadcast-ID helper and slave FSM states.
package stage_ctrl_pkg;

  localparam logic [2:0] STAGE_IDLE   = 3'd0;
  localparam logic [2:0] STAGE_LOAD   = 3'd1;
  localparam logic [2:0] STAGE_GROW   = 3'd2;
  localparam logic [2:0] STAGE_MERGE  = 3'd3;
  localparam logic [2:0] STAGE_RESULT = 3'd4;
  localparam logic [2:0] STAGE_ACK    = 3'd7;

  // Bit offsets counted down from the payload MSB (payload[W-OFS]).
  localparam int unsigned CMD_BIT_OFS      = 1;
  localparam int unsigned ACK_ODD_BIT_OFS  = 2;
  localparam int unsigned ACK_DLCK_BIT_OFS = 3;

  // Width of the stage-code field at the bottom of a command payload.
  localparam int unsigned STAGE_CODE_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_APPLY,
    S_SETTLE,
    S_REPORT
  } slave_state_e;

  // All-ones destination of the given width (the broadcast address).
  function automatic logic [31:0] broadcast_id(input int unsigned width);
    if (width >= 32) begin
      broadcast_id = '1;
    end else begin
      broadcast_id = (32'd1 << width) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/hub_dest_filter.sv
// Destination decode for words arriving from the hub: accept broadcast
// and words addressed to this leaf, everything else is to be dropped.
module hub_dest_filter
  import stage_ctrl_pkg::*;
#(
  parameter int              DEST_W = 7,
  parameter logic [DEST_W-1:0] MY_ID  = DEST_W'(1)
) (
  input  logic [DEST_W-1:0] dest_i,
  output logic              accept_o
);

  localparam logic [DEST_W-1:0] BCAST_ID = DEST_W'(broadcast_id(DEST_W));

  assign accept_o = (dest_i == BCAST_ID) || (dest_i == MY_ID);

endmodule

// File: rtl/stage_controller_slave.sv
// Leaf endpoint of the stage-controller protocol. Accepts one command at a
// time, drives the local stage, waits for local activity to settle and
// returns an acknowledge; forwards direct messages to the PU array.
// Optional settle watchdog: define STAGE_SLAVE_WATCHDOG_EN.
module stage_controller_slave
  import stage_ctrl_pkg::*;
#(
  parameter int HUB_FIFO_WIDTH    = 16,
  parameter int MASTER_FIFO_WIDTH = 9,
  parameter logic [HUB_FIFO_WIDTH-MASTER_FIFO_WIDTH-1:0] MY_ID =
    (HUB_FIFO_WIDTH-MASTER_FIFO_WIDTH)'(1),
  parameter int SETTLE_CYCLES     = 3,
  parameter int WATCHDOG_LIMIT    = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [HUB_FIFO_WIDTH-1:0]    fifo_in_data,
  input  logic                         fifo_in_valid,
  output logic                         fifo_in_ready,
  output logic [HUB_FIFO_WIDTH-1:0]    fifo_out_data,
  output logic                         fifo_out_valid,
  input  logic                         fifo_out_ready,
  output logic [MASTER_FIFO_WIDTH-2:0] direct_out_data,
  output logic                         direct_out_valid,
  input  logic                         direct_out_ready,
  output logic [2:0]                   stage,
  input  logic                         local_has_message_flying,
  input  logic                         local_has_odd_clusters,
  output logic                         upstream_has_message_flying,
  output logic                         upstream_has_odd_clusters,
  output logic                         dropped_pulse,
  output logic                         deadlock
);

  localparam int DEST_W = HUB_FIFO_WIDTH - MASTER_FIFO_WIDTH;
  localparam int MW     = MASTER_FIFO_WIDTH;
  localparam int QW     = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  slave_state_e        state_q, state_d;
  logic [2:0]          stage_q, stage_d;
  logic [2:0]          code_q, code_d;
  logic [MW-2:0]       direct_q, direct_d;
  logic [QW-1:0]       quiet_q, quiet_d;
  logic                odd_q, odd_d;
  logic                drop_q, drop_d;
  logic                up_fly_q, up_odd_q;
  logic                in_ready, out_valid, dir_valid;
  logic                accept;
  logic                wd_hit;
  logic                deadlock_flag;
  logic [DEST_W-1:0]   in_dest;
  logic [MW-1:0]       in_payload;
  logic [MW-1:0]       ack_payload;

  assign in_dest    = fifo_in_data[HUB_FIFO_WIDTH-1:MW];
  assign in_payload = fifo_in_data[MW-1:0];

  hub_dest_filter #(
    .DEST_W (DEST_W),
    .MY_ID  (MY_ID)
  ) u_dest_filter (
    .dest_i   (in_dest),
    .accept_o (accept)
  );

`ifdef STAGE_SLAVE_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_LIMIT + 1);

  logic [WD_W-1:0] wd_q;
  logic            deadlock_q;

  assign wd_hit = (state_q == S_SETTLE) && (wd_q == WD_W'(WATCHDOG_LIMIT - 1));

  // Count cycles spent settling; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (reset || (state_q != S_SETTLE)) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  // Deadlock flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      deadlock_q <= 1'b0;
    end else if (wd_hit) begin
      deadlock_q <= 1'b1;
    end
  end

  assign deadlock_flag = deadlock_q;
`else
  // Watchdog limit only matters when the watchdog is built in.
  logic unused_wd_limit;
  assign unused_wd_limit = ^WATCHDOG_LIMIT;
  assign wd_hit          = 1'b0;
  assign deadlock_flag   = 1'b0;
`endif

  // Next-state and handshake decode for the command/forward/ack sequence.
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    code_d    = code_q;
    direct_d  = direct_q;
    quiet_d   = quiet_q;
    odd_d     = odd_q;
    drop_d    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dir_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (fifo_in_valid) begin
          if (!accept) begin
            drop_d = 1'b1;
          end else if (in_payload[MW-CMD_BIT_OFS]) begin
            code_d  = in_payload[STAGE_CODE_W-1:0];
            state_d = S_APPLY;
          end else begin
            direct_d = in_payload[MW-2:0];
            state_d  = S_FWD;
          end
        end
      end
      S_FWD: begin
        dir_valid = 1'b1;
        if (direct_out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_APPLY: begin
        stage_d = code_q;
        quiet_d = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        quiet_d = local_has_message_flying ? '0 : (quiet_q + QW'(1));
        if ((quiet_d == QW'(SETTLE_CYCLES)) || wd_hit) begin
          odd_d   = local_has_odd_clusters;
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        out_valid = 1'b1;
        if (fifo_out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, stage, settle counter and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      stage_q  <= STAGE_IDLE;
      quiet_q  <= '0;
      drop_q   <= 1'b0;
      up_fly_q <= 1'b0;
      up_odd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      quiet_q  <= quiet_d;
      drop_q   <= drop_d;
      up_fly_q <= local_has_message_flying || (state_q != S_IDLE);
      up_odd_q <= local_has_odd_clusters;
    end
  end

  // Latched command code, forwarded payload and odd flag (data only).
  always_ff @(posedge clk) begin
    code_q   <= code_d;
    direct_q <= direct_d;
    odd_q    <= odd_d;
  end

  // Acknowledge payload: command marker, odd flag, deadlock flag, ACK code.
  always_comb begin
    ack_payload                    = '0;
    ack_payload[MW-CMD_BIT_OFS]    = 1'b1;
    ack_payload[MW-ACK_ODD_BIT_OFS]  = odd_q;
    ack_payload[MW-ACK_DLCK_BIT_OFS] = deadlock_flag;
    ack_payload[STAGE_CODE_W-1:0]  = STAGE_ACK;
  end

  assign fifo_in_ready    = in_ready && !reset;
  assign fifo_out_valid   = out_valid && !reset;
  assign fifo_out_data    = (state_q == S_REPORT) ? {{DEST_W{1'b0}}, ack_payload}
                                                  : '0;
  assign direct_out_valid = dir_valid && !reset;
  assign direct_out_data  = direct_q;
  assign stage            = stage_q;
  assign upstream_has_message_flying = up_fly_q;
  assign upstream_has_odd_clusters   = up_odd_q;
  assign dropped_pulse    = drop_q;
  assign deadlock         = deadlock_flag;

endmodule

// File: tb/tb_stage_controller_slave.sv
// Directed bench for stage_controller_slave: broadcast command, foreign
// destination drop, settle restart, stalled forward, reset abort and the
// settle watchdog (or its absence, in the default build).
module tb_stage_controller_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fifo_in_data;
  logic        fifo_in_valid;
  logic        fifo_in_ready;
  logic [15:0] fifo_out_data;
  logic        fifo_out_valid;
  logic        fifo_out_ready;
  logic [7:0]  direct_out_data;
  logic        direct_out_valid;
  logic        direct_out_ready;
  logic [2:0]  stage;
  logic        local_has_message_flying;
  logic        local_has_odd_clusters;
  logic        upstream_has_message_flying;
  logic        upstream_has_odd_clusters;
  logic        dropped_pulse;
  logic        deadlock;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  always #5 clk = ~clk;

  stage_controller_slave #(
    .HUB_FIFO_WIDTH    (16),
    .MASTER_FIFO_WIDTH (9),
    .MY_ID             (7'd1),
    .SETTLE_CYCLES     (3),
    .WATCHDOG_LIMIT    (20)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .fifo_in_data                (fifo_in_data),
    .fifo_in_valid               (fifo_in_valid),
    .fifo_in_ready               (fifo_in_ready),
    .fifo_out_data               (fifo_out_data),
    .fifo_out_valid              (fifo_out_valid),
    .fifo_out_ready              (fifo_out_ready),
    .direct_out_data             (direct_out_data),
    .direct_out_valid            (direct_out_valid),
    .direct_out_ready            (direct_out_ready),
    .stage                       (stage),
    .local_has_message_flying    (local_has_message_flying),
    .local_has_odd_clusters      (local_has_odd_clusters),
    .upstream_has_message_flying (upstream_has_message_flying),
    .upstream_has_odd_clusters   (upstream_has_odd_clusters),
    .dropped_pulse               (dropped_pulse),
    .deadlock                    (deadlock)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word and let the edge consume it.
  task automatic send(input logic [15:0] word);
    fifo_in_data  = word;
    fifo_in_valid = 1'b1;
    step();
    fifo_in_valid = 1'b0;
    fifo_in_data  = '0;
  endtask

  initial begin
    reset = 1'b1;
    fifo_in_data = '0;
    fifo_in_valid = 1'b0;
    fifo_out_ready = 1'b0;
    direct_out_ready = 1'b0;
    local_has_message_flying = 1'b0;
    local_has_odd_clusters = 1'b0;

    // Reset state
    step();
    check("rst_in_ready", fifo_in_ready, 0);
    check("rst_out_valid", fifo_out_valid, 0);
    check("rst_dir_valid", direct_out_valid, 0);
    check("rst_stage", stage, 0);
    check("rst_up_fly", upstream_has_message_flying, 0);
    check("rst_up_odd", upstream_has_odd_clusters, 0);
    check("rst_deadlock", deadlock, 0);
    check("rst_dropped", dropped_pulse, 0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", fifo_in_ready, 1);

    // 1: broadcast GROW, quiet locally
    send({7'h7F, 9'h102});
    check("t1_ready_busy", fifo_in_ready, 0);
    check("t1_stage_before", stage, 0);
    step();
    check("t1_stage", stage, 2);
    step();
    check("t1_valid_c2", fifo_out_valid, 0);
    step();
    check("t1_valid_c3", fifo_out_valid, 0);
    step();
    check("t1_valid_c4", fifo_out_valid, 1);
    check("t1_ack", fifo_out_data, 16'h0107);
    step();
    check("t1_valid_hold", fifo_out_valid, 1);
    check("t1_ack_hold", fifo_out_data, 16'h0107);
    fifo_out_ready = 1'b1;
    step();
    fifo_out_ready = 1'b0;
    #1;
    check("t1_valid_done", fifo_out_valid, 0);
    check("t1_ready_back", fifo_in_ready, 1);
    check("t1_stage_kept", stage, 2);
    check("t1_up_fly_busy", upstream_has_message_flying, 1);
    step();
    check("t1_up_fly_idle", upstream_has_message_flying, 0);

    // 2: command for another leaf is dropped
    send({7'd5, 9'h103});
    check("t2_dropped", dropped_pulse, 1);
    check("t2_ready", fifo_in_ready, 1);
    check("t2_stage", stage, 2);
    step();
    check("t2_dropped_end", dropped_pulse, 0);
    check("t2_no_ack", fifo_out_valid, 0);

    // 3: MERGE with local activity and a one-cycle quiet glitch
    local_has_message_flying = 1'b1;
    local_has_odd_clusters = 1'b1;
    send({7'd1, 9'h103});
    for (int c = 1; c <= 13; c++) begin
      local_has_message_flying = (c == 4 || c >= 11) ? 1'b0 : 1'b1;
      step();
      if (c == 1) check("t3_stage", stage, 3);
      check($sformatf("t3_valid_c%0d", c), fifo_out_valid, (c == 13) ? 1 : 0);
    end
    check("t3_ack", fifo_out_data, 16'h0187);
    check("t3_up_odd", upstream_has_odd_clusters, 1);
    local_has_odd_clusters = 1'b0;
    step();
    check("t3_ack_stable", fifo_out_data, 16'h0187);
    fifo_out_ready = 1'b1;
    step();
    fifo_out_ready = 1'b0;
    #1;
    check("t3_valid_done", fifo_out_valid, 0);
    check("t3_deadlock", deadlock, 0);

    // 4: direct message held by a stalled PU array
    send({7'd1, 9'h02A});
    fifo_in_data  = {7'h7F, 9'h101};
    fifo_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("t4_dir_valid", direct_out_valid, 1);
      check("t4_dir_data", direct_out_data, 8'h2A);
      check("t4_in_ready", fifo_in_ready, 0);
      step();
    end
    fifo_in_valid = 1'b0;
    fifo_in_data  = '0;
    direct_out_ready = 1'b1;
    #1;
    check("t4_dir_valid_hs", direct_out_valid, 1);
    step();
    direct_out_ready = 1'b0;
    #1;
    check("t4_dir_done", direct_out_valid, 0);
    check("t4_ready_back", fifo_in_ready, 1);
    check("t4_stage", stage, 3);

    // 5: reset while the acknowledge is pending
    send({7'h7F, 9'h101});
    step(); step(); step(); step();
    check("t5_valid", fifo_out_valid, 1);
    check("t5_ack", fifo_out_data, 16'h0107);
    check("t5_stage", stage, 1);
    reset = 1'b1;
    step();
    check("t5_rst_valid", fifo_out_valid, 0);
    check("t5_rst_stage", stage, 0);
    check("t5_rst_ready", fifo_in_ready, 0);
    reset = 1'b0;
    #1;
    check("t5_idle_ready", fifo_in_ready, 1);
    check("t5_idle_valid", fifo_out_valid, 0);

`ifdef STAGE_SLAVE_WATCHDOG_EN
    // 6: flying stuck high trips the watchdog
    local_has_message_flying = 1'b1;
    send({7'h7F, 9'h102});
    n = 0;
    while (!fifo_out_valid && n < 40) begin
      step();
      n++;
    end
    check("t6_latency", n, 21);
    check("t6_deadlock", deadlock, 1);
    check("t6_ack", fifo_out_data, 16'h0147);
    fifo_out_ready = 1'b1;
    step();
    fifo_out_ready = 1'b0;
    step();
    check("t6_deadlock_sticky", deadlock, 1);
    check("t6_valid_done", fifo_out_valid, 0);
`else
    // 6: without the watchdog, settle waits for as long as activity lasts
    local_has_message_flying = 1'b1;
    send({7'h7F, 9'h102});
    for (int c = 0; c < 30; c++) step();
    check("t6_wait_valid", fifo_out_valid, 0);
    check("t6_no_deadlock", deadlock, 0);
    local_has_message_flying = 1'b0;
    step(); step(); step();
    check("t6_late_valid", fifo_out_valid, 1);
    check("t6_late_ack", fifo_out_data, 16'h0107);
    fifo_out_ready = 1'b1;
    step();
    fifo_out_ready = 1'b0;
    #1;
    check("t6_valid_done", fifo_out_valid, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stage_controller_slave.md
Name: stage_controller_slave

Overview:
- Leaf-side endpoint of the stage-controller protocol. The root master broadcasts stage commands down the hub FIFO tree; this block receives them.
- For each accepted command it decodes the destination, drives the local decoder stage and waits for local activity to settle. It then returns one acknowledge message upstream.
- It also forwards direct (non-command) messages to the local PU array and reports its local flying/odd status as level signals toward the hub.

Parameters:
- HUB_FIFO_WIDTH, 16, full hub word width (destination field + payload).
- MASTER_FIFO_WIDTH, 9, payload width in bits [MASTER_FIFO_WIDTH-1:0].
- MY_ID, 7'd1, destination ID of this leaf; width is HUB_FIFO_WIDTH-MASTER_FIFO_WIDTH.
- SETTLE_CYCLES, 3, consecutive quiet cycles required before acknowledging.
- WATCHDOG_LIMIT, 1023, settle-timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fifo_in_data  in  HUB_FIFO_WIDTH  word from the upstream hub
- fifo_in_valid  in  1  input word valid
- fifo_in_ready  out  1  block accepts the input word
- fifo_out_data  out  HUB_FIFO_WIDTH  acknowledge word sent upstream
- fifo_out_valid  out  1  acknowledge valid
- fifo_out_ready  in  1  hub accepts the acknowledge
- direct_out_data  out  MASTER_FIFO_WIDTH-1  forwarded direct message
- direct_out_valid  out  1  forwarded message valid
- direct_out_ready  in  1  PU array accepts the forwarded message
- stage  out  3  current local stage code
- local_has_message_flying  in  1  OR of PU message activity
- local_has_odd_clusters  in  1  OR of PU odd-root flags
- upstream_has_message_flying  out  1  registered status to the hub
- upstream_has_odd_clusters  out  1  registered status to the hub
- dropped_pulse  out  1  one-cycle pulse when a word addressed elsewhere is consumed
- deadlock  out  1  sticky settle-timeout flag

Behaviour:
- Word format:
  - dest = data[HUB-1:MASTER].
  - payload[MASTER-1] = 1 marks a command; 0 marks a direct message.
  - For a command, payload[2:0] is the stage code.
- Stage codes: IDLE=0, LOAD=1, GROW=2, MERGE=3, RESULT=4, ACK=7.
- Address decode: a word is accepted if dest is all ones (broadcast) or dest == MY_ID. Otherwise it is consumed and dropped_pulse is asserted for exactly 1 cycle.
- FSM states: S_IDLE, S_FWD, S_APPLY, S_SETTLE, S_REPORT.
- S_IDLE:
  - fifo_in_ready = 1; this is the only state with ready high.
  - A handshake on an accepted command latches the code and moves to S_APPLY.
  - A handshake on an accepted direct message latches payload[MASTER-2:0] and moves to S_FWD.
- S_FWD: direct_out_valid = 1 and the data is held stable. On direct_out_ready, return to S_IDLE.
- S_APPLY:
  - stage <= latched code on the following edge, so stage changes exactly 1 cycle after the input handshake.
  - Go to S_SETTLE and clear the quiet counter.
- S_SETTLE:
  - The quiet counter increments while local_has_message_flying = 0 and resets to 0 when it is 1.
  - When the counter reaches SETTLE_CYCLES, go to S_REPORT.
  - For LOAD, IDLE and RESULT, the counter still runs; the flying input is honoured uniformly.
- S_REPORT:
  - fifo_out_valid = 1.
  - fifo_out_data: dest = 0 (root), payload[MASTER-1] = 1, [MASTER-2] = local_has_odd_clusters sampled on S_REPORT entry, [MASTER-3] = deadlock, [2:0] = ACK, all other bits 0.
  - Data stays stable until fifo_out_ready; then go to S_IDLE.
  - stage keeps its value after the acknowledge; it changes only on the next command.
- Status outputs (registered, 1 cycle latency):
  - upstream_has_message_flying = local_has_message_flying OR (state != S_IDLE).
  - upstream_has_odd_clusters = local_has_odd_clusters.
- Reset values: stage = IDLE, all valid and ready outputs 0 in the reset cycle, upstream status 0, deadlock 0, dropped_pulse 0, FSM = S_IDLE.
- Reset mid-operation aborts any pending acknowledge or forward; no partial word is emitted.
- Back-to-back commands: the next word is not accepted until the acknowledge handshake completes, so at most one command is outstanding.
- A local_has_message_flying glitch during S_SETTLE restarts the quiet count.

Optional Feature:
- Macro: STAGE_SLAVE_WATCHDOG_EN.
- With the macro defined:
  - A watchdog counter counts cycles spent in S_SETTLE.
  - At WATCHDOG_LIMIT, deadlock is set (sticky until reset) and the FSM moves to S_REPORT with the deadlock bit set in the acknowledge.
- Without the macro: no watchdog counter exists, deadlock is tied to 0, and S_SETTLE can wait indefinitely.

Decomposition:
- Shared package stage_ctrl_pkg:
  - Stage-code localparams.
  - The command/ACK bit-position constants.
  - A broadcast-ID helper function.
  - The FSM state typedef.
- Optional sub-module hub_dest_filter: a combinational accept/drop decode of the destination field. The FSM stays in the main module.

Test Plan:
1. Broadcast GROW (dest=7'h7F, payload=9'h102), local flying=0 → stage=2 one cycle after the handshake; ACK word 16'h0107 appears 1+3 cycles later; handshake completes, FSM returns to S_IDLE.
2. Command with dest=7'd5, MY_ID=1 → word consumed, dropped_pulse high for 1 cycle, stage unchanged, no acknowledge.
3. MERGE with local flying=1 for 10 cycles, a 1-cycle drop at cycle 4, local odd=1 → acknowledge delayed until 3 quiet cycles after cycle 10; ACK payload bit7=1 (word 16'h0187).
4. Direct message 9'h02A to dest MY_ID with direct_out_ready held 0 for 5 cycles → direct_out_data=8'h2A stays stable; fifo_in_ready stays 0 until the forward handshake.
5. Reset asserted while in S_REPORT with fifo_out_ready=0 → next cycle fifo_out_valid=0, stage=0, FSM=S_IDLE.
6. With STAGE_SLAVE_WATCHDOG_EN, WATCHDOG_LIMIT=20, flying stuck at 1 → deadlock=1 at cycle 20; ACK bit6=1; deadlock remains 1 after the acknowledge.
